// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IFU/LSU data-memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEM_LAT    = 1;
    localparam int WMASK_WIDTH    = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        GNT_IFU = 1'b0,
        GNT_LSU = 1'b1
    } gnt_e;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection between IFU and LSU requesters.
// MEM_ARB_ROUND_ROBIN_EN alternates grants on ties; otherwise LSU always wins a tie.
module mem_arb_picker
    import mem_arb_pkg::*;
(
    input  logic ifu_valid_i,
    input  logic lsu_valid_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last_gnt_i,
`endif
    output logic any_valid_o,
    output logic winner_o
);

    always_comb begin
        any_valid_o = ifu_valid_i | lsu_valid_i;
        winner_o    = GNT_IFU;
        if (ifu_valid_i && lsu_valid_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            winner_o = (last_gnt_i == GNT_LSU) ? GNT_IFU : GNT_LSU;
`else
            winner_o = GNT_LSU;
`endif
        end else if (lsu_valid_i) begin
            winner_o = GNT_LSU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises IFU fetches and LSU loads/stores onto one memory port, one transaction at a time.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking instead of LSU priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_LAT    = DEF_MEM_LAT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ifu_req_valid,
    output logic                   ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0]  ifu_req_addr,
    output logic                   ifu_resp_valid,
    input  logic                   ifu_resp_ready,
    output logic [DATA_WIDTH-1:0]  ifu_resp_rdata,
    input  logic                   lsu_req_valid,
    output logic                   lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0]  lsu_req_addr,
    input  logic                   lsu_req_wen,
    input  logic [DATA_WIDTH-1:0]  lsu_req_wdata,
    input  logic [WMASK_WIDTH-1:0] lsu_req_wmask,
    output logic                   lsu_resp_valid,
    input  logic                   lsu_resp_ready,
    output logic [DATA_WIDTH-1:0]  lsu_resp_rdata,
    output logic                   mem_valid,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic                   mem_wen,
    output logic [WMASK_WIDTH-1:0] mem_wmask,
    input  logic [DATA_WIDTH-1:0]  mem_rdata
);

    localparam int               CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    state_e                 state_q, state_d;
    logic                   gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   wen_q, wen_d;
    logic [WMASK_WIDTH-1:0] wmask_q, wmask_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   pick_valid;
    logic                   pick_winner;
    logic                   resp_taken;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_gnt_q, last_gnt_d;
`endif

    mem_arb_picker u_picker (
        .ifu_valid_i (ifu_req_valid),
        .lsu_valid_i (lsu_req_valid),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_gnt_i  (last_gnt_q),
`endif
        .any_valid_o (pick_valid),
        .winner_o    (pick_winner)
    );

    assign resp_taken = (gnt_q == GNT_LSU) ? lsu_resp_ready : ifu_resp_ready;

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wen_d         = wen_q;
        wmask_d       = wmask_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_gnt_d    = last_gnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    ifu_req_ready = (pick_winner == GNT_IFU);
                    lsu_req_ready = (pick_winner == GNT_LSU);
                    gnt_d         = pick_winner;
                    cnt_d         = CNT_LOAD;
                    state_d       = ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_gnt_d    = pick_winner;
`endif
                    if (pick_winner == GNT_LSU) begin
                        addr_d  = lsu_req_addr;
                        wen_d   = lsu_req_wen;
                        wdata_d = lsu_req_wdata;
                        wmask_d = lsu_req_wmask;
                    end else begin
                        addr_d  = ifu_req_addr;
                        wen_d   = 1'b0;
                        wmask_d = '0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    rdata_d = wen_q ? '0 : mem_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_taken) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: synchronous reset inside the clocked block; all state uses non-blocking assignments.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= GNT_IFU;
            addr_q  <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            wmask_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            wmask_q <= wmask_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Starts at IFU so the first tie after reset goes to the LSU.
    always_ff @(posedge clock) begin
        if (reset) last_gnt_q <= GNT_IFU;
        else       last_gnt_q <= last_gnt_d;
    end
`endif

    assign mem_valid      = (state_q == ACCESS);
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wen        = mem_valid & wen_q;
    assign mem_wmask      = mem_valid ? wmask_q : '0;
    assign ifu_resp_valid = (state_q == RESP) && (gnt_q == GNT_IFU);
    assign lsu_resp_valid = (state_q == RESP) && (gnt_q == GNT_LSU);
    assign ifu_resp_rdata = rdata_q;
    assign lsu_resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance 0 with MEM_LAT=1, instance 1 with MEM_LAT=3,
// each backed by a small negedge-write memory model.
module tb_mem_arbiter;

    typedef struct packed {
        logic        is_lsu;
        logic [31:0] data;
    } exp_t;

    logic        clock;
    logic        rst            [2];
    logic        ifu_rv         [2];
    logic        ifu_rr         [2];
    logic [31:0] ifu_addr       [2];
    logic        ifu_resp_valid [2];
    logic        ifu_resp_ready [2];
    logic [31:0] ifu_resp_rdata [2];
    logic        lsu_rv         [2];
    logic        lsu_rr         [2];
    logic [31:0] lsu_addr       [2];
    logic        lsu_wen        [2];
    logic [31:0] lsu_wdata      [2];
    logic [3:0]  lsu_wmask      [2];
    logic        lsu_resp_valid [2];
    logic        lsu_resp_ready [2];
    logic [31:0] lsu_resp_rdata [2];
    logic        mem_valid      [2];
    logic [31:0] mem_addr       [2];
    logic [31:0] mem_wdata      [2];
    logic        mem_wen        [2];
    logic [3:0]  mem_wmask      [2];
    logic [31:0] mem_rdata      [2];
    logic [31:0] mem            [2][64];

    exp_t sb0[$];
    exp_t sb1[$];
    int   total = 0;
    int   bad   = 0;

    mem_arbiter #(.MEM_LAT(1)) dut1 (
        .clock(clock), .reset(rst[0]),
        .ifu_req_valid(ifu_rv[0]), .ifu_req_ready(ifu_rr[0]), .ifu_req_addr(ifu_addr[0]),
        .ifu_resp_valid(ifu_resp_valid[0]), .ifu_resp_ready(ifu_resp_ready[0]),
        .ifu_resp_rdata(ifu_resp_rdata[0]),
        .lsu_req_valid(lsu_rv[0]), .lsu_req_ready(lsu_rr[0]), .lsu_req_addr(lsu_addr[0]),
        .lsu_req_wen(lsu_wen[0]), .lsu_req_wdata(lsu_wdata[0]), .lsu_req_wmask(lsu_wmask[0]),
        .lsu_resp_valid(lsu_resp_valid[0]), .lsu_resp_ready(lsu_resp_ready[0]),
        .lsu_resp_rdata(lsu_resp_rdata[0]),
        .mem_valid(mem_valid[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_wen(mem_wen[0]), .mem_wmask(mem_wmask[0]), .mem_rdata(mem_rdata[0])
    );

    mem_arbiter #(.MEM_LAT(3)) dut3 (
        .clock(clock), .reset(rst[1]),
        .ifu_req_valid(ifu_rv[1]), .ifu_req_ready(ifu_rr[1]), .ifu_req_addr(ifu_addr[1]),
        .ifu_resp_valid(ifu_resp_valid[1]), .ifu_resp_ready(ifu_resp_ready[1]),
        .ifu_resp_rdata(ifu_resp_rdata[1]),
        .lsu_req_valid(lsu_rv[1]), .lsu_req_ready(lsu_rr[1]), .lsu_req_addr(lsu_addr[1]),
        .lsu_req_wen(lsu_wen[1]), .lsu_req_wdata(lsu_wdata[1]), .lsu_req_wmask(lsu_wmask[1]),
        .lsu_resp_valid(lsu_resp_valid[1]), .lsu_resp_ready(lsu_resp_ready[1]),
        .lsu_resp_rdata(lsu_resp_rdata[1]),
        .mem_valid(mem_valid[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_wen(mem_wen[1]), .mem_wmask(mem_wmask[1]), .mem_rdata(mem_rdata[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: preloaded while in reset, byte-masked writes on negedge, combinational read.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                for (int i = 0; i < 64; i++) mem[d][i] <= 32'h0;
                mem[d][0] <= 32'hDEADBEEF;
                mem[d][2] <= 32'h11111111;
                mem[d][4] <= 32'hAAAAAAAA;
                mem[d][8] <= 32'hCAFEF00D;
                mem[d][9] <= 32'h0BADC0DE;
            end else if (mem_valid[d] && mem_wen[d]) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[d][b]) mem[d][mem_addr[d][7:2]][8*b +: 8] <= mem_wdata[d][8*b +: 8];
            end
        end
    end
    assign mem_rdata[0] = mem[0][mem_addr[0][7:2]];
    assign mem_rdata[1] = mem[1][mem_addr[1][7:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        check(name, {31'h0, act}, {31'h0, exp});
    endtask

    function automatic void push_exp(input int d, input exp_t e);
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endfunction

    task automatic pop_check(input int d, input logic is_lsu, input logic [31:0] data);
        exp_t e;
        if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL resp_unexpected: dut%0d lsu=%0b data=0x%08h with empty queue", d, is_lsu, data);
        end else begin
            e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            check_b("resp_port", is_lsu, e.is_lsu);
            check("resp_data", data, e.data);
        end
    endtask

    // Monitor: every completed response handshake is compared with the oldest expectation.
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst[d]) begin
                if (ifu_resp_valid[d] && ifu_resp_ready[d]) pop_check(d, 1'b0, ifu_resp_rdata[d]);
                if (lsu_resp_valid[d] && lsu_resp_ready[d]) pop_check(d, 1'b1, lsu_resp_rdata[d]);
            end
        end
    end

    task automatic do_req(input int d, input int lat, input logic is_lsu, input logic [31:0] addr,
                          input logic wen, input logic [31:0] wdata, input logic [3:0] wmask,
                          input logic [31:0] exp_data, input string tag);
        int   n;
        logic got;
        @(negedge clock);
        if (is_lsu) begin
            lsu_rv[d] = 1'b1; lsu_addr[d] = addr; lsu_wen[d] = wen;
            lsu_wdata[d] = wdata; lsu_wmask[d] = wmask;
        end else begin
            ifu_rv[d] = 1'b1; ifu_addr[d] = addr;
        end
        #1;
        n   = 0;
        got = is_lsu ? lsu_rr[d] : ifu_rr[d];
        while (!got && n < 20) begin
            @(negedge clock); #1;
            n++;
            got = is_lsu ? lsu_rr[d] : ifu_rr[d];
        end
        check_b({tag, "_ready"}, got, 1'b1);
        if (got) begin
            push_exp(d, {is_lsu, exp_data});
            @(posedge clock); #1;
            ifu_rv[d] = 1'b0; lsu_rv[d] = 1'b0;
            ifu_addr[d] = '1; lsu_addr[d] = '1; lsu_wdata[d] = 32'h0; lsu_wmask[d] = 4'hF;
            lsu_wen[d] = ~wen;
            for (int c = 1; c <= lat; c++) begin
                check_b({tag, "_mem_valid"}, mem_valid[d], 1'b1);
                check({tag, "_mem_addr"}, mem_addr[d], addr);
                check_b({tag, "_mem_wen"}, mem_wen[d], wen);
                check({tag, "_mem_wmask"}, {28'h0, mem_wmask[d]}, {28'h0, (is_lsu ? wmask : 4'h0)});
                if (wen) check({tag, "_mem_wdata"}, mem_wdata[d], wdata);
                check_b({tag, "_early_resp"}, ifu_resp_valid[d] | lsu_resp_valid[d], 1'b0);
                @(posedge clock); #1;
            end
            check_b({tag, "_mem_valid_end"}, mem_valid[d], 1'b0);
            check_b({tag, "_mem_wen_end"}, mem_wen[d], 1'b0);
            check_b({tag, "_resp_valid"}, is_lsu ? lsu_resp_valid[d] : ifu_resp_valid[d], 1'b1);
            n = 0;
            while ((ifu_resp_valid[d] || lsu_resp_valid[d]) && n < 50) begin
                @(posedge clock); #1;
                n++;
            end
            check_b({tag, "_resp_done"}, ifu_resp_valid[d] | lsu_resp_valid[d], 1'b0);
        end else begin
            ifu_rv[d] = 1'b0; lsu_rv[d] = 1'b0;
        end
    endtask

    logic order [3];
    int   n_ties;
    int   n;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; ifu_rv[d] = 1'b0; ifu_addr[d] = 32'h0; ifu_resp_ready[d] = 1'b1;
            lsu_rv[d] = 1'b0; lsu_addr[d] = 32'h0; lsu_wen[d] = 1'b0; lsu_wdata[d] = 32'h0;
            lsu_wmask[d] = 4'h0; lsu_resp_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            check_b("rst_mem_valid", mem_valid[d], 1'b0);
            check_b("rst_ready", ifu_rr[d] | lsu_rr[d], 1'b0);
            check_b("rst_resp_valid", ifu_resp_valid[d] | lsu_resp_valid[d], 1'b0);
            check("rst_mem_addr", mem_addr[d], 32'h0);
            check("rst_mem_wdata", mem_wdata[d], 32'h0);
            check("rst_rdata", ifu_resp_rdata[d] | lsu_resp_rdata[d], 32'h0);
        end
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Simultaneous requests straight after reset.
`ifdef MEM_ARB_ROUND_ROBIN_EN
        n_ties = 3; order[0] = 1'b1; order[1] = 1'b0; order[2] = 1'b1;
`else
        n_ties = 2; order[0] = 1'b1; order[1] = 1'b0; order[2] = 1'b0;
`endif
        @(negedge clock);
        lsu_rv[0] = 1'b1; lsu_addr[0] = 32'h80000008; lsu_wen[0] = 1'b0; lsu_wmask[0] = 4'h0;
        ifu_rv[0] = 1'b1; ifu_addr[0] = 32'h80000000;
        for (int k = 0; k < n_ties; k++) begin
            #1;
            n = 0;
            while (!(lsu_rr[0] || ifu_rr[0]) && n < 20) begin
                @(negedge clock); #1;
                n++;
            end
            check_b("tie_lsu_ready", lsu_rr[0], order[k]);
            check_b("tie_ifu_ready", ifu_rr[0], ~order[k]);
            push_exp(0, order[k] ? {1'b1, 32'h11111111} : {1'b0, 32'hDEADBEEF});
            @(posedge clock); #1;
`ifndef MEM_ARB_ROUND_ROBIN_EN
            if (k == 0) lsu_rv[0] = 1'b0;
`endif
            if (k == n_ties - 1) begin
                lsu_rv[0] = 1'b0; ifu_rv[0] = 1'b0;
            end
            @(negedge clock);
        end
        repeat (6) @(posedge clock);
        #1;
        check("tie_drain", sb0.size(), 32'd0);

        // Single transactions on the MEM_LAT=1 instance.
        do_req(0, 1, 1'b0, 32'h80000000, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, "ifu_rd");
        do_req(0, 1, 1'b1, 32'h80000010, 1'b1, 32'h12345678, 4'b0011, 32'h0, "lsu_wr");
        do_req(0, 1, 1'b1, 32'h80000010, 1'b0, 32'h0, 4'h0, 32'hAAAA5678, "lsu_rd_back");

        // LSU response stalled for 5 cycles while the IFU keeps requesting.
        lsu_resp_ready[0] = 1'b0;
        @(negedge clock);
        lsu_rv[0] = 1'b1; lsu_addr[0] = 32'h80000008; lsu_wen[0] = 1'b0;
        ifu_rv[0] = 1'b1; ifu_addr[0] = 32'h80000000;
        #1;
        check_b("stall_lsu_ready", lsu_rr[0], 1'b1);
        check_b("stall_ifu_blocked", ifu_rr[0], 1'b0);
        push_exp(0, {1'b1, 32'h11111111});
        @(posedge clock); #1;
        lsu_rv[0] = 1'b0;
        check_b("stall_ifu_access", ifu_rr[0], 1'b0);
        @(posedge clock); #1;
        for (int k = 0; k < 5; k++) begin
            check_b("stall_resp_valid", lsu_resp_valid[0], 1'b1);
            check("stall_resp_rdata", lsu_resp_rdata[0], 32'h11111111);
            check_b("stall_ifu_ready", ifu_rr[0], 1'b0);
            @(posedge clock); #1;
        end
        lsu_resp_ready[0] = 1'b1;
        push_exp(0, {1'b0, 32'hDEADBEEF});
        @(negedge clock); #1;
        n = 0;
        while (!ifu_rr[0] && n < 20) begin
            @(negedge clock); #1;
            n++;
        end
        check_b("stall_ifu_after", ifu_rr[0], 1'b1);
        @(posedge clock); #1;
        ifu_rv[0] = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check("stall_drain", sb0.size(), 32'd0);

        // MEM_LAT=3 instance: plain read, then reset in the middle of an access.
        do_req(1, 3, 1'b0, 32'h80000020, 1'b0, 32'h0, 4'h0, 32'hCAFEF00D, "lat3_rd");
        @(negedge clock);
        ifu_rv[1] = 1'b1; ifu_addr[1] = 32'h80000024;
        #1;
        check_b("rstmid_ready", ifu_rr[1], 1'b1);
        @(posedge clock); #1;
        ifu_rv[1] = 1'b0;
        check_b("rstmid_access", mem_valid[1], 1'b1);
        @(posedge clock); #1;
        rst[1] = 1'b1;
        @(posedge clock); #1;
        rst[1] = 1'b0;
        check_b("rstmid_mem_valid", mem_valid[1], 1'b0);
        check_b("rstmid_mem_wen", mem_wen[1], 1'b0);
        check_b("rstmid_resp", ifu_resp_valid[1], 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            check_b("rstmid_quiet", ifu_resp_valid[1] | mem_valid[1], 1'b0);
        end
        do_req(1, 3, 1'b0, 32'h80000024, 1'b0, 32'h0, 4'h0, 32'h0BADC0DE, "lat3_after_rst");

        repeat (4) @(posedge clock);
        #1;
        check("final_drain0", sb0.size(), 32'd0);
        check("final_drain1", sb1.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
